// File: rtl/lrpt_pkg.sv
// Shared LRPT coding constants, encoder state type and parity helper.
// Used by the K=7 encoder and the decoder branch-metric tables.
package lrpt_pkg;

    localparam int K   = 7;
    localparam int MEM = 6;

    localparam logic [K-1:0] G0_DEF = 7'b1111001;
    localparam logic [K-1:0] G1_DEF = 7'b1011011;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FLUSH
    } enc_state_t;

    function automatic logic conv_parity(
        input logic [K-1:0] w,
        input logic [K-1:0] g
    );
        return ^(w & g);
    endfunction

endpackage

// File: rtl/conv_encoder_k7.sv
// Streaming rate-1/2 K=7 convolutional encoder with zero-tail termination.
// One-deep output register; sr ordering matches the decoder state numbering.
module conv_encoder_k7
    import lrpt_pkg::*;
#(
    parameter logic [K-1:0] G0        = G0_DEF,
    parameter logic [K-1:0] G1        = G1_DEF,
    parameter bit           INVERT_G1 = 1'b0,
    parameter bit           TAIL_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       bit_in,
    input  logic       valid_in,
    input  logic       last_in,
    output logic       ready_out,
    output logic [1:0] sym_out,
    output logic       valid_out,
    output logic       last_out,
    input  logic       ready_in,
    output logic       busy
);

    localparam logic [2:0] TAIL_LAST = 3'(MEM - 1);

    enc_state_t     state_q, state_d;
    logic [MEM-1:0] sr_q, sr_d;
    logic [2:0]     tail_q, tail_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic [1:0]     sym_q, sym_d;

    logic           adv;
    logic           take;
    logic           enc_en;
    logic           enc_bit;
    logic           enc_last;
    logic [K-1:0]   win;
    logic [1:0]     sym_new;

    assign adv       = !valid_q || ready_in;
    assign ready_out = sys_rst_n && adv && (state_q != FLUSH);
    assign take      = valid_in && ready_out;
    assign busy      = (state_q != IDLE);

    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign sym_out   = sym_q;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DATA: begin
                if (take) begin
                    if (!last_in) begin
                        state_d = DATA;
                    end else if (TAIL_EN) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (adv && tail_q == TAIL_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tail bits are produced on every output advance, not on input transfers.
    always_comb begin
        enc_en   = 1'b0;
        enc_bit  = 1'b0;
        enc_last = 1'b0;
        case (state_q)
            IDLE, DATA: begin
                enc_en   = take;
                enc_bit  = bit_in;
                enc_last = last_in && !TAIL_EN;
            end
            FLUSH: begin
                enc_en   = adv;
                enc_bit  = 1'b0;
                enc_last = (tail_q == TAIL_LAST);
            end
            default: begin
                enc_en   = 1'b0;
                enc_bit  = 1'b0;
                enc_last = 1'b0;
            end
        endcase
    end

    assign win     = {enc_bit, sr_q};
    assign sym_new = {conv_parity(win, G0),
                      conv_parity(win, G1) ^ INVERT_G1};

    always_comb begin
        sr_d    = sr_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        last_d  = last_q;
        sym_d   = sym_q;
        if (enc_en) begin
            sr_d = enc_last ? '0 : {enc_bit, sr_q[MEM-1:1]};
        end
        if (state_q == FLUSH && adv) begin
            tail_d = (tail_q == TAIL_LAST) ? 3'd0 : tail_q + 3'd1;
        end
        if (adv) begin
            valid_d = enc_en;
            last_d  = enc_en && enc_last;
            if (enc_en) begin
                sym_d = sym_new;
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr_q    <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sym_q   <= 2'b00;
        end else begin
            sr_q    <= sr_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sym_q   <= sym_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Bench for conv_encoder_k7: frame-history reference model checked every
// cycle, plus literal symbol sequences for the directed frames.
module tb_conv_encoder_k7;

    localparam logic [6:0] MG0 = 7'o171;
    localparam logic [6:0] MG1 = 7'o133;

    logic       clk;
    logic       sys_rst_n;
    logic       bit_in;
    logic       valid_in;
    logic       last_in;
    logic       ready_out;
    logic [1:0] sym_out;
    logic       valid_out;
    logic       last_out;
    logic       ready_in;
    logic       busy;

    logic       inv_ready;
    logic [1:0] inv_sym;
    logic       inv_valid;
    logic       inv_last;
    logic       inv_busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ro_low = 0;

    bit         hist[$];
    logic [2:0] exp_q[$];
    logic [2:0] log_q[$];
    logic [1:0] log_inv[$];
    int         acc_q[$];
    int         term_q[$];
    logic       busy_at_term;

    conv_encoder_k7 dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .bit_in    (bit_in),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .ready_out (ready_out),
        .sym_out   (sym_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .ready_in  (ready_in),
        .busy      (busy)
    );

    conv_encoder_k7 #(.INVERT_G1(1'b1)) dut_inv (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .bit_in    (bit_in),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .ready_out (inv_ready),
        .sym_out   (inv_sym),
        .valid_out (inv_valid),
        .last_out  (inv_last),
        .ready_in  (ready_in),
        .busy      (inv_busy)
    );

    initial begin
        if (lrpt_pkg::G0_DEF[6] !== 1'b1 || lrpt_pkg::G1_DEF[6] !== 1'b1)
            $fatal(1, "FAIL gen_msb: generator bit 6 must be 1");
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endfunction

    // Symbol for the newest frame bit from the full frame history.
    function automatic void push_bit(input bit b, input bit last);
        bit s1, s0;
        int n;
        hist.push_back(b);
        n  = hist.size() - 1;
        s1 = 1'b0;
        s0 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (n - i >= 0) begin
                s1 ^= MG0[6-i] & hist[n-i];
                s0 ^= MG1[6-i] & hist[n-i];
            end
        end
        exp_q.push_back({last, s1, s0});
    endfunction

    function automatic void model_accept(input bit b, input bit last);
        push_bit(b, 1'b0);
        if (last) begin
            for (int t = 0; t < 6; t++) push_bit(1'b0, t == 5);
            hist.delete();
        end
    endfunction

    always @(negedge clk) begin
        logic [2:0] e;
        cyc++;
        if (sys_rst_n) begin
            tests++;
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sym_spurious: got sym=%b last=%b expected none",
                             sym_out, last_out);
                end else begin
                    e = exp_q[0];
                    if ({last_out, sym_out} !== e ||
                        {inv_valid, inv_last, inv_sym} !== {1'b1, e[2], e[1:0] ^ 2'b01}) begin
                        fails++;
                        $display("FAIL sym: got last=%b sym=%b inv=%b/%b expected last=%b sym=%b",
                                 last_out, sym_out, inv_valid, inv_sym, e[2], e[1:0]);
                    end
                    if (ready_in) begin
                        log_q.push_back({last_out, sym_out});
                        log_inv.push_back(inv_sym);
                        if (last_out) begin
                            term_q.push_back(cyc);
                            busy_at_term = busy;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end else if (inv_valid !== 1'b0 || last_out !== 1'b0) begin
                fails++;
                $display("FAIL idle: got inv_valid=%b last=%b expected 0 0",
                         inv_valid, last_out);
            end
            if (valid_in && ready_out) begin
                acc_q.push_back(cyc);
                model_accept(bit_in, last_in);
            end
            if (!ready_out) ro_low++;
        end
    end

    task automatic send_frame(input logic [31:0] bits, input int n, input bit hold);
        int k;
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            bit_in   = bits[i];
            last_in  = (i == n - 1);
            k = 0;
            @(negedge clk);
            while (!ready_out) begin
                k++;
                if (k > 500) break;
                @(negedge clk);
            end
            if (k > 500) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: got no ready_out expected accept");
            end
            @(posedge clk);
            #1;
        end
        if (!hold) begin
            valid_in = 1'b0;
            last_in  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        @(negedge clk);
        #1;
        while (exp_q.size() != 0 || valid_out) begin
            k++;
            if (k > 400) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_q.delete();
        log_inv.delete();
        acc_q.delete();
        term_q.delete();
    endtask

    task automatic check_impulse(input string tag);
        logic [1:0] imp[7];
        logic [1:0] impi[7];
        imp  = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
        impi = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b01, 2'b00, 2'b10};
        chk({tag, "_len"}, log_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < log_q.size()) begin
                chk($sformatf("%s_sym%0d", tag, i), log_q[i][1:0], imp[i]);
                chk($sformatf("%s_last%0d", tag, i), log_q[i][2], i == 6);
                chk($sformatf("%s_inv%0d", tag, i), log_inv[i], impi[i]);
            end
        end
    endtask

    initial begin
        logic [1:0] b2b[8];
        logic [31:0] rb;
        int   k;
        bit   done;

        sys_rst_n = 1'b0;
        valid_in  = 1'b0;
        bit_in    = 1'b0;
        last_in   = 1'b0;
        ready_in  = 1'b1;
        busy_at_term = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_last", last_out, 0);
        chk("rst_sym", sym_out, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // impulse, both polarities of G1
        clear_logs();
        send_frame(32'h1, 1, 1'b0);
        wait_drain();
        check_impulse("imp");
        chk("imp_busy_term", busy_at_term, 0);
        chk("imp_busy_after", busy, 0);

        // all-zero frame: ready_out low for the six tail slots only
        clear_logs();
        ro_low = 0;
        send_frame(32'h0, 3, 1'b0);
        wait_drain();
        chk("zero_len", log_q.size(), 9);
        for (int i = 0; i < log_q.size(); i++) begin
            chk($sformatf("zero_sym%0d", i), log_q[i][1:0], 0);
            chk($sformatf("zero_last%0d", i), log_q[i][2], i == 8);
        end
        chk("zero_ready_low", ro_low, 6);

        // backpressure on a random 8-bit frame
        clear_logs();
        rb = $urandom;
        fork
            send_frame(rb, 8, 1'b0);
            begin
                k = 0;
                @(negedge clk);
                #1;
                while (log_q.size() < 3 && k < 200) begin
                    k++;
                    @(negedge clk);
                    #1;
                end
                @(posedge clk);
                #1;
                ready_in = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", valid_out, 1);
                    chk("bp_ready", ready_out, 0);
                    chk("bp_hold", {last_out, sym_out}, exp_q.size() ? exp_q[0] : 3'b111);
                end
                @(posedge clk);
                #1;
                ready_in = 1'b1;
            end
        join
        wait_drain();
        chk("bp_len", log_q.size(), 14);

        // back-to-back frames {1} then {1,1}
        clear_logs();
        send_frame(32'h1, 1, 1'b1);
        send_frame(32'h3, 2, 1'b0);
        wait_drain();
        chk("b2b_len", log_q.size(), 15);
        chk("b2b_acc", acc_q.size(), 3);
        if (acc_q.size() >= 2 && term_q.size() >= 1)
            chk("b2b_next_accept", acc_q[1] - term_q[0], 0);
        else
            chk("b2b_events", acc_q.size() + term_q.size(), 5);
        b2b = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            if (7 + i < log_q.size()) begin
                chk($sformatf("b2b_sym%0d", i), log_q[7+i][1:0], b2b[i]);
                chk($sformatf("b2b_last%0d", i), log_q[7+i][2], i == 7);
            end
        end

        // reset in the middle of the tail
        clear_logs();
        send_frame(32'h1, 1, 1'b0);
        k = 0;
        while (log_q.size() < 4 && k < 200) begin
            k++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_last", last_out, 0);
        chk("mid_rst_ready", ready_out, 0);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete();
        hist.delete();
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(32'h1, 1, 1'b0);
        wait_drain();
        check_impulse("rst_imp");

        // random frames under random downstream stalls
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    send_frame($urandom, $urandom_range(1, 12), f[0]);
                end
                valid_in = 1'b0;
                last_in  = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ready_in = ($urandom_range(0, 3) != 0);
                end
                ready_in = 1'b1;
            end
        join
        wait_drain();
        chk("rand_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
